fir_xifu_ex: RTL and testbench

- Execute stage of the FIR XIFU coprocessor pipeline. Sits between decode/operand-read and the write-back stage.
- Accepts one decoded instruction at a time.
- XFIRLW/XFIRSW: issues the XIF memory request and computes the post-incremented base address.
- XFIRDOTP: performs a 2-cycle 2x16-bit signed dot-product-accumulate.
- Drives the EX/WB pipeline register consumed by write-back.

---
 rtl/fir_xifu_ex.sv | 225 ++++++++++++++++++++++
 tb/tb_fir_xifu_ex.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_ex.sv
// ============================================================================
//  Module   : fir_xifu_ex
//  Purpose  : FIR XIFU execute stage (XIF memory requests, 2-cycle dot-product).
//             Optional write-back bypass on operand A: define FIR_XIFU_EX_FWD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_xifu_ex #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned IMM_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [1:0]           instr_i,
    input  logic [ID_WIDTH-1:0]  id_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rd_i,
    input  logic [31:0]          op_a_i,
    input  logic [31:0]          op_b_i,
    input  logic [31:0]          op_c_i,
    input  logic [IMM_WIDTH-1:0] imm_i,
    input  logic                 wb_fwd_we_i,
    input  logic [4:0]           wb_fwd_rd_i,
    input  logic [31:0]          wb_fwd_result_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_wdata_o,
    output logic [ID_WIDTH-1:0]  mem_id_o,
    input  logic                 wb_ready_i,
    input  logic                 kill_i,
    output logic [1:0]           ex_instr_o,
    output logic [ID_WIDTH-1:0]  ex_id_o,
    output logic [4:0]           ex_rd_o,
    output logic [4:0]           ex_rs1_o,
    output logic [31:0]          ex_result_o
);

    localparam logic [1:0] OP_INVALID = 2'd0;
    localparam logic [1:0] OP_SW      = 2'd2;
    localparam logic [1:0] OP_DOTP    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MEM  = 3'd1,
        ST_MUL  = 3'd2,
        ST_ACC  = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  init_q;
    logic [1:0]            instr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [4:0]            rs1_q, rd_q;
    logic [31:0]           a_q, b_q, c_q;
    logic [IMM_WIDTH-1:0]  imm_q;
    logic [31:0]           p0_q, p1_q;
    logic [31:0]           res_q;
    logic [1:0]            ex_instr_q;
    logic [ID_WIDTH-1:0]   ex_id_q;
    logic [4:0]            ex_rd_q, ex_rs1_q;
    logic [31:0]           ex_result_q;

    logic                  hazard;
    logic                  accept;
    logic                  load;
    logic [31:0]           a_capture;
    logic [31:0]           imm_ext;
    logic [31:0]           addr_sum;
    logic [31:0]           acc_sum;
    logic [31:0]           result;
    logic signed [31:0]    p0_d, p1_d;

    assign hazard = wb_fwd_we_i && (wb_fwd_rd_i == rs1_i) && (rs1_i != 5'd0);

`ifdef FIR_XIFU_EX_FWD_EN
    assign ready_o   = init_q && (state_q == ST_IDLE) && !kill_i;
    assign a_capture = hazard ? wb_fwd_result_i : op_a_i;
`else
    // Without the bypass, hold off until the register file has the value.
    assign ready_o   = init_q && (state_q == ST_IDLE) && !kill_i && !hazard;
    assign a_capture = op_a_i;
`endif

    assign accept   = valid_i && ready_o && (instr_i != OP_INVALID);
    assign imm_ext  = {{(32-IMM_WIDTH){imm_q[IMM_WIDTH-1]}}, imm_q};
    assign addr_sum = a_q + imm_ext;
    assign acc_sum  = c_q + p0_q + p1_q;
    assign p0_d     = $signed(a_q[15:0])  * $signed(b_q[15:0]);
    assign p1_d     = $signed(a_q[31:16]) * $signed(b_q[31:16]);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        result  = res_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (instr_i == OP_DOTP) ? ST_MUL : ST_MEM;
                end
            end
            ST_MEM: begin
                result = addr_sum;
                if (mem_ready_i) begin
                    if (wb_ready_i) begin
                        load    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_MUL: begin
                state_d = ST_ACC;
            end
            ST_ACC: begin
                result = acc_sum;
                if (wb_ready_i) begin
                    load    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (wb_ready_i) begin
                    load    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (kill_i) begin
            state_d = ST_IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= OP_INVALID;
            id_q    <= '0;
            rs1_q   <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            imm_q   <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            res_q   <= '0;
        end else begin
            if (accept) begin
                instr_q <= instr_i;
                id_q    <= id_i;
                rs1_q   <= rs1_i;
                rd_q    <= rd_i;
                a_q     <= a_capture;
                b_q     <= op_b_i;
                c_q     <= op_c_i;
                imm_q   <= imm_i;
            end
            if (state_q == ST_MUL) begin
                p0_q <= p0_d;
                p1_q <= p1_d;
            end
            // Keeps the finished result available while write-back stalls.
            if ((state_q == ST_MEM) || (state_q == ST_ACC)) begin
                res_q <= result;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_instr_q  <= OP_INVALID;
            ex_id_q     <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_result_q <= '0;
        end else if (kill_i) begin
            ex_instr_q  <= OP_INVALID;
        end else if (load) begin
            ex_instr_q  <= instr_q;
            ex_id_q     <= id_q;
            ex_rd_q     <= rd_q;
            ex_rs1_q    <= rs1_q;
            ex_result_q <= result;
        end else if (wb_ready_i) begin
            ex_instr_q  <= OP_INVALID;
        end
    end

    assign mem_valid_o = (state_q == ST_MEM);
    assign mem_addr_o  = a_q;
    assign mem_we_o    = (state_q == ST_MEM) && (instr_q == OP_SW);
    assign mem_wdata_o = b_q;
    assign mem_id_o    = id_q;

    assign ex_instr_o  = ex_instr_q;
    assign ex_id_o     = ex_id_q;
    assign ex_rd_o     = ex_rd_q;
    assign ex_rs1_o    = ex_rs1_q;
    assign ex_result_o = ex_result_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_xifu_ex.sv
// ============================================================================
//  Module   : tb_fir_xifu_ex
//  Purpose  : Scoreboard bench for fir_xifu_ex with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_xifu_ex;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  instr_i = '0;
    logic [3:0]  id_i = '0;
    logic [4:0]  rs1_i = '0, rd_i = '0;
    logic [31:0] op_a_i = '0, op_b_i = '0, op_c_i = '0;
    logic [11:0] imm_i = '0;
    logic        wb_fwd_we_i = 1'b0;
    logic [4:0]  wb_fwd_rd_i = '0;
    logic [31:0] wb_fwd_result_i = '0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_id_o;
    logic        wb_ready_i = 1'b1;
    logic        kill_i = 1'b0;
    logic [1:0]  ex_instr_o;
    logic [3:0]  ex_id_o;
    logic [4:0]  ex_rd_o, ex_rs1_o;
    logic [31:0] ex_result_o;

    fir_xifu_ex #(.ID_WIDTH(4), .IMM_WIDTH(12)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .id_i(id_i), .rs1_i(rs1_i), .rd_i(rd_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i), .imm_i(imm_i),
        .wb_fwd_we_i(wb_fwd_we_i), .wb_fwd_rd_i(wb_fwd_rd_i), .wb_fwd_result_i(wb_fwd_result_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_id_o(mem_id_o),
        .wb_ready_i(wb_ready_i), .kill_i(kill_i),
        .ex_instr_o(ex_instr_o), .ex_id_o(ex_id_o), .ex_rd_o(ex_rd_o),
        .ex_rs1_o(ex_rs1_o), .ex_result_o(ex_result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  instr;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] result;
    } ex_t;

    ex_t         exp_q[$];
    ex_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          seen = 1'b0;
    int          mem_lat = 0, mem_cnt = 0, req_len = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_id = '0;
    int          acc0, acc1, acc2;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_ex(input logic [1:0] ins, input logic [3:0] id, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [31:0] res);
        ex_t e;
        e.instr = ins; e.id = id; e.rd = rd; e.rs1 = rs1; e.result = res;
        exp_q.push_back(e);
    endtask

    // Returns at accept edge + 1ns with valid_i dropped.
    task automatic issue(input logic [1:0] ins, input logic [3:0] id, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [11:0] imm, output int acc_cyc);
        bit ok = 1'b0;
        instr_i = ins; id_i = id; rs1_i = rs1; rd_i = rd;
        op_a_i = a; op_b_i = b; op_c_i = c; imm_i = imm; valid_i = 1'b1;
        acc_cyc = -1;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready_o stayed 0 for id %0d", id);
        end else begin
            acc_cyc = cyc;
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        instr_i = 2'd0;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_ready_timeout: ready_o stayed 0");
        end
        tick();
    endtask

    // Monitor: each fresh EX/WB entry is compared once against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            seen = 1'b0;
        end else begin
            if ((ex_instr_o != 2'd0) && !seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ex_unexpected: got instr %0d id %0d result 0x%08h, required none",
                             ex_instr_o, ex_id_o, ex_result_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ex_instr",  {30'd0, ex_instr_o}, {30'd0, mon_e.instr});
                    chk("ex_id",     {28'd0, ex_id_o},    {28'd0, mon_e.id});
                    chk("ex_rd",     {27'd0, ex_rd_o},    {27'd0, mon_e.rd});
                    chk("ex_rs1",    {27'd0, ex_rs1_o},   {27'd0, mon_e.rs1});
                    chk("ex_result", ex_result_o,         mon_e.result);
                end
            end
            seen = (ex_instr_o != 2'd0) && !wb_ready_i;
        end
    end

    // Memory responder: grants after mem_lat wait cycles, checks request fields every cycle.
    always @(negedge clk_i) begin
        if (rst_ni && mem_valid_o) begin
            chk("mem_addr", mem_addr_o, exp_addr);
            chk("mem_we",   {31'd0, mem_we_o}, {31'd0, exp_we});
            chk("mem_id",   {28'd0, mem_id_o}, {28'd0, exp_id});
            if (exp_we) chk("mem_wdata", mem_wdata_o, exp_wdata);
            mem_ready_i = (mem_cnt >= mem_lat);
            mem_cnt++;
            if (mem_ready_i) begin
                req_len = mem_cnt;
                mem_cnt = 0;
            end
        end else begin
            mem_ready_i = 1'b0;
            mem_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready",     {31'd0, ready_o},     32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("rst_ex_instr",  {30'd0, ex_instr_o},  32'd0);
        chk("rst_ex_result", ex_result_o,          32'd0);
        rst_ni = 1'b1;
        #1;
        chk("ready_at_release", {31'd0, ready_o}, 32'd0);
        tick();
        chk("ready_after_release", {31'd0, ready_o}, 32'd1);

        // LW with two memory wait cycles
        exp_addr = 32'h1000; exp_we = 1'b0; exp_id = 4'd1; mem_lat = 2;
        expect_ex(2'd1, 4'd1, 5'd3, 5'd2, 32'h0000_1004);
        issue(2'd1, 4'd1, 5'd2, 5'd3, 32'h1000, 32'hDEAD_BEEF, 32'd0, 12'd4, acc0);
        wait_ready();
        chk("lw_req_len", req_len, 32'd3);

        // LW with negative immediate and address wrap
        exp_addr = 32'h2; exp_we = 1'b0; exp_id = 4'd3; mem_lat = 0;
        expect_ex(2'd1, 4'd3, 5'd9, 5'd4, 32'hFFFF_FFFE);
        issue(2'd1, 4'd3, 5'd4, 5'd9, 32'h2, 32'd0, 32'd0, 12'hFFC, acc0);
        wait_ready();
        chk("lw2_req_len", req_len, 32'd1);

        // DOTP latency and result
        expect_ex(2'd3, 4'd2, 5'd7, 5'd6, 32'd12);
        issue(2'd3, 4'd2, 5'd6, 5'd7, 32'h0002_FFFF, 32'h0003_0004, 32'd10, 12'd0, acc0);
        tick();
        chk("dotp_not_yet", {30'd0, ex_instr_o}, 32'd0);
        tick();
        chk("dotp_lat2_instr",  {30'd0, ex_instr_o}, 32'd3);
        chk("dotp_lat2_result", ex_result_o, 32'd12);
        tick();
        chk("dotp_bubble", {30'd0, ex_instr_o}, 32'd0);

        // DOTP extremes with wrap
        expect_ex(2'd3, 4'd10, 5'd1, 5'd2, 32'h7FFF_0000);
        issue(2'd3, 4'd10, 5'd2, 5'd1, 32'h8000_7FFF, 32'h8000_7FFF, 32'hFFFF_FFFF, 12'd0, acc0);
        wait_ready();

        // SW stalled by write-back
        exp_addr = 32'h3000; exp_we = 1'b1; exp_wdata = 32'hCAFE_BABE; exp_id = 4'd4; mem_lat = 0;
        wb_ready_i = 1'b0;
        expect_ex(2'd2, 4'd4, 5'd11, 5'd12, 32'h0000_37FF);
        issue(2'd2, 4'd4, 5'd12, 5'd11, 32'h3000, 32'hCAFE_BABE, 32'd0, 12'h7FF, acc0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("hold_ready",     {31'd0, ready_o},     32'd0);
            chk("hold_mem_valid", {31'd0, mem_valid_o}, 32'd0);
            chk("hold_ex_instr",  {30'd0, ex_instr_o},  32'd0);
            tick();
        end
        wb_ready_i = 1'b1;
        tick();
        chk("hold_load_instr",  {30'd0, ex_instr_o}, 32'd2);
        chk("hold_load_result", ex_result_o, 32'h0000_37FF);
        chk("hold_ready_after", {31'd0, ready_o}, 32'd1);
        tick();

        // Kill during MEM
        exp_addr = 32'h4000; exp_we = 1'b0; exp_id = 4'd5; mem_lat = 10;
        issue(2'd1, 4'd5, 5'd1, 5'd1, 32'h4000, 32'd0, 32'd0, 12'd8, acc0);
        tick();
        kill_i = 1'b1;
        #1;
        chk("kill_ready_low", {31'd0, ready_o}, 32'd0);
        tick();
        kill_i = 1'b0;
        #1;
        chk("kill_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("kill_ex_instr",  {30'd0, ex_instr_o},  32'd0);
        chk("kill_ready",     {31'd0, ready_o},     32'd1);
        tick();

        // Kill during ACC suppresses the EX/WB load
        issue(2'd3, 4'd6, 5'd1, 5'd1, 32'h0001_0001, 32'h0001_0001, 32'd0, 12'd0, acc0);
        tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        #1;
        chk("kill_acc_ex_instr", {30'd0, ex_instr_o}, 32'd0);
        chk("kill_acc_ready",    {31'd0, ready_o},    32'd1);
        tick();

        // Write-back hazard on rs1
        wb_fwd_we_i = 1'b1; wb_fwd_rd_i = 5'd5; wb_fwd_result_i = 32'h2000;
        exp_addr = 32'h2000; exp_we = 1'b0; exp_id = 4'd6; mem_lat = 0;
        expect_ex(2'd1, 4'd6, 5'd8, 5'd5, 32'h0000_2010);
`ifdef FIR_XIFU_EX_FWD_EN
        #1;
        chk("fwd_ready", {31'd0, ready_o}, 32'd1);
        issue(2'd1, 4'd6, 5'd5, 5'd8, 32'h1111, 32'd0, 32'd0, 12'd16, acc0);
        wb_fwd_we_i = 1'b0;
`else
        instr_i = 2'd1; id_i = 4'd6; rs1_i = 5'd5; rd_i = 5'd8; op_a_i = 32'h1111; valid_i = 1'b1;
        #1;
        chk("hazard_ready_low", {31'd0, ready_o}, 32'd0);
        tick();
        chk("hazard_ready_low2", {31'd0, ready_o}, 32'd0);
        wb_fwd_we_i = 1'b0;
        issue(2'd1, 4'd6, 5'd5, 5'd8, 32'h2000, 32'd0, 32'd0, 12'd16, acc0);
`endif
        wait_ready();

        // Back-to-back DOTPs
        expect_ex(2'd3, 4'd7, 5'd13, 5'd14, 32'd2);
        expect_ex(2'd3, 4'd8, 5'd15, 5'd16, 32'd1);
        expect_ex(2'd3, 4'd9, 5'd17, 5'd18, 32'h7FFE_0003);
        issue(2'd3, 4'd7, 5'd14, 5'd13, 32'h0001_0001, 32'h0001_0001, 32'd0, 12'd0, acc0);
        issue(2'd3, 4'd8, 5'd16, 5'd15, 32'hFFFF_FFFF, 32'h0002_0002, 32'd5, 12'd0, acc1);
        issue(2'd3, 4'd9, 5'd18, 5'd17, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'd1, 12'd0, acc2);
        chk("b2b_gap1", acc1 - acc0, 32'd3);
        chk("b2b_gap2", acc2 - acc1, 32'd3);
        wait_ready();

        // Asynchronous reset mid-operation
        exp_addr = 32'h5000; exp_we = 1'b1; exp_wdata = 32'h1234_5678; exp_id = 4'd11; mem_lat = 10;
        issue(2'd2, 4'd11, 5'd3, 5'd3, 32'h5000, 32'h1234_5678, 32'd0, 12'd4, acc0);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_mem_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("async_mem_addr",  mem_addr_o,           32'd0);
        chk("async_ready",     {31'd0, ready_o},     32'd0);
        chk("async_ex_result", ex_result_o,          32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        chk("async_ready_back", {31'd0, ready_o}, 32'd1);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
